// File: rtl/tetris_pkg.sv
// Shared board geometry, index widths and movement FSM encoding for the Tetris datapath.
package tetris_pkg;

  localparam int unsigned BOARD_ROWS = 16;
  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned ROW_W      = 4;
  localparam int unsigned COL_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } move_state_e;

endpackage

// File: rtl/repeat_timer.sv
// Auto-repeat countdown for a held button: first expiry after DELAY cycles, then every RATE cycles.
module repeat_timer #(
  parameter int unsigned DELAY = 12,
  parameter int unsigned RATE  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic rate_sel,
  input  logic hold,
  input  logic clear,
  output logic expire_c
);

  localparam int unsigned MAXV  = (DELAY > RATE) ? DELAY : RATE;
  localparam int unsigned CNT_W = $clog2(MAXV + 1);

  logic             armed;
  logic [CNT_W-1:0] count;

  // Releasing the button or a new piece drops any pending repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
      count <= '0;
    end else if (clear || !hold) begin
      armed <= 1'b0;
      count <= '0;
    end else if (arm) begin
      armed <= 1'b1;
      count <= rate_sel ? CNT_W'(RATE) : CNT_W'(DELAY);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire_c = armed & hold & (count == CNT_W'(1));

endmodule

// File: rtl/right_movement_ctrl.sv
// Right-shift controller for the falling piece: edge/auto-repeat trigger, board row lookup,
// wall and collision check, spawn reload.
module right_movement_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned ROWS         = BOARD_ROWS,
  parameter int unsigned COLS         = BOARD_COLS,
  parameter int unsigned SPAWN_COL    = 4,
  parameter int unsigned REPEAT_DELAY = 12,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             move_req,
  input  logic             load,
  input  logic [COL_W-1:0] spawn_col,
  input  logic [ROW_W-1:0] vert_block,
  output logic             row_rd,
  output logic [ROW_W-1:0] row_addr,
  input  logic [COLS-1:0]  row_data,
  output logic [COL_W-1:0] hor_block,
  output logic             moved,
  output logic             blocked,
  output logic             busy
);

  if (ROWS > (1 << ROW_W)) begin : g_rows_chk
    $error("ROWS does not fit the row address width");
  end
  if (COLS > (1 << COL_W) || SPAWN_COL >= COLS) begin : g_cols_chk
    $error("COLS or SPAWN_COL does not fit the column index width");
  end

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  move_state_e      state, state_n;
  logic [COL_W-1:0] hor_n, next_col;
  logic [ROW_W-1:0] row_addr_n;
  logic             moved_n, blocked_n, row_rd_n;
  logic             move_prev, rel_seen;
  logic             edge_c, expire_c, trig_c, at_wall;
  logic             tmr_arm, tmr_rate;

  // A press only counts after the button has been seen released since reset.
  assign edge_c   = move_req & ~move_prev & rel_seen;
  assign trig_c   = (edge_c | expire_c) & (state == IDLE);
  assign at_wall  = (hor_block == LAST_COL);
  assign next_col = at_wall ? hor_block : hor_block + COL_W'(1);

  repeat_timer #(
    .DELAY (REPEAT_DELAY),
    .RATE  (REPEAT_RATE)
  ) u_repeat_timer (
    .clk      (clk),
    .rst      (rst),
    .arm      (tmr_arm),
    .rate_sel (tmr_rate),
    .hold     (move_req),
    .clear    (load),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hor_block <= COL_W'(SPAWN_COL);
      moved     <= 1'b0;
      blocked   <= 1'b0;
      row_rd    <= 1'b0;
      row_addr  <= '0;
      busy      <= 1'b0;
      move_prev <= 1'b0;
      rel_seen  <= 1'b0;
    end else begin
      state     <= state_n;
      hor_block <= hor_n;
      moved     <= moved_n;
      blocked   <= blocked_n;
      row_rd    <= row_rd_n;
      row_addr  <= row_addr_n;
      busy      <= (state_n != IDLE);
      move_prev <= move_req;
      rel_seen  <= rel_seen | ~move_req;
    end
  end

  // Row data returns during WAIT, so the move is resolved as WAIT hands over to CHECK.
  always_comb begin
    state_n    = state;
    hor_n      = hor_block;
    moved_n    = 1'b0;
    blocked_n  = 1'b0;
    row_rd_n   = 1'b0;
    row_addr_n = row_addr;
    tmr_arm    = 1'b0;
    tmr_rate   = 1'b0;
    if (load) begin
      state_n = IDLE;
      hor_n   = (spawn_col > LAST_COL) ? LAST_COL : spawn_col;
    end else begin
      unique case (state)
        IDLE: begin
          if (trig_c) begin
            tmr_arm  = 1'b1;
            tmr_rate = ~edge_c;
            if (at_wall) begin
              blocked_n = 1'b1;
            end else begin
              state_n    = READ;
              row_rd_n   = 1'b1;
              row_addr_n = vert_block;
            end
          end
        end
        READ: state_n = WAIT;
        WAIT: begin
          state_n = CHECK;
          if (row_data[next_col]) begin
            blocked_n = 1'b1;
          end else begin
            hor_n   = next_col;
            moved_n = 1'b1;
          end
        end
        CHECK: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_right_movement_ctrl.sv
// Directed bench for right_movement_ctrl: single moves, wall, collision, auto-repeat, load and reset aborts.
module tb_right_movement_ctrl;

  localparam int unsigned ROWS = 16;
  localparam int unsigned COLS = 10;

  logic            clk = 1'b0;
  logic            rst, move_req, load;
  logic [3:0]      spawn_col, vert_block, row_addr, hor_block;
  logic            row_rd, moved, blocked, busy;
  logic [COLS-1:0] row_data;
  logic [COLS-1:0] board [ROWS];

  int vectors     = 0;
  int miscompares = 0;
  int rd_cnt      = 0;
  int rd_mark     = 0;
  int events      = 0;

  right_movement_ctrl #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .SPAWN_COL    (4),
    .REPEAT_DELAY (12),
    .REPEAT_RATE  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .move_req   (move_req),
    .load       (load),
    .spawn_col  (spawn_col),
    .vert_block (vert_block),
    .row_rd     (row_rd),
    .row_addr   (row_addr),
    .row_data   (row_data),
    .hor_block  (hor_block),
    .moved      (moved),
    .blocked    (blocked),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Board memory: one-cycle read latency, junk (all ones) when not read.
  always @(posedge clk) begin
    row_data <= row_rd ? board[row_addr] : '1;
    if (row_rd === 1'b1) rd_cnt <= rd_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] col);
    load      = 1'b1;
    spawn_col = col;
    step();
    load      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; move_req = 1'b0; load = 1'b0; spawn_col = '0; vert_block = '0;
    for (int r = 0; r < ROWS; r++) board[r] = '0;
    board[2] = 10'h010;

    // Reset state
    step(); step();
    chk("rst_hor", hor_block, 4);
    chk("rst_moved", moved, 0);
    chk("rst_blocked", blocked, 0);
    chk("rst_row_rd", row_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_row_addr", row_addr, 0);
    rst = 1'b0;
    step();

    // Free move from column 4 on row 7
    vert_block = 4'd7; move_req = 1'b1;
    step();
    chk("a_t1_row_rd", row_rd, 1);
    chk("a_t1_row_addr", row_addr, 7);
    chk("a_t1_busy", busy, 1);
    chk("a_t1_moved", moved, 0);
    move_req = 1'b0;
    step();
    chk("a_t2_busy", busy, 1);
    chk("a_t2_row_rd", row_rd, 0);
    chk("a_t2_hor", hor_block, 4);
    step();
    chk("a_t3_moved", moved, 1);
    chk("a_t3_blocked", blocked, 0);
    chk("a_t3_hor", hor_block, 5);
    step();
    chk("a_t4_moved", moved, 0);
    chk("a_t4_busy", busy, 0);

    // Wall: column 9 cannot move right, no row read
    do_load(4'd9);
    chk("b_load_hor", hor_block, 9);
    rd_mark = rd_cnt;
    move_req = 1'b1;
    step();
    chk("b_t1_blocked", blocked, 1);
    chk("b_t1_moved", moved, 0);
    chk("b_t1_busy", busy, 0);
    chk("b_t1_row_rd", row_rd, 0);
    move_req = 1'b0;
    step();
    chk("b_t2_blocked", blocked, 0);
    step(); step();
    chk("b_no_reads", rd_cnt, rd_mark);
    chk("b_hor", hor_block, 9);

    // Collision: column 4 of row 2 occupied; row change after latch ignored
    do_load(4'd3);
    chk("c_load_hor", hor_block, 3);
    vert_block = 4'd2; move_req = 1'b1;
    step();
    chk("c_t1_row_addr", row_addr, 2);
    chk("c_t1_row_rd", row_rd, 1);
    vert_block = 4'd7; move_req = 1'b0;
    step(); step();
    chk("c_t3_blocked", blocked, 1);
    chk("c_t3_moved", moved, 0);
    chk("c_t3_hor", hor_block, 3);
    step();
    chk("c_t4_blocked", blocked, 0);
    chk("c_t4_busy", busy, 0);

    // Load during WAIT aborts the move and clamps spawn column
    vert_block = 4'd7; move_req = 1'b1;
    step();
    chk("d_t1_busy", busy, 1);
    move_req = 1'b0;
    step();
    load = 1'b1; spawn_col = 4'd12;
    step();
    load = 1'b0;
    chk("d_hor", hor_block, 9);
    chk("d_moved", moved, 0);
    chk("d_blocked", blocked, 0);
    chk("d_busy", busy, 0);
    chk("d_row_rd", row_rd, 0);
    step();
    chk("d_late_moved", moved, 0);
    chk("d_late_blocked", blocked, 0);
    chk("d_late_hor", hor_block, 9);

    // Held button: move at 3, repeats every 12 then 4 cycles, then blocked at the wall
    do_load(4'd0);
    vert_block = 4'd7; move_req = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      logic mv_exp, bl_exp;
      step();
      mv_exp = (k == 3) || (k >= 15 && k <= 43 && ((k - 15) % 4) == 0);
      bl_exp = (k >= 45) && (((k - 45) % 4) == 0);
      chk($sformatf("e_moved_k%0d", k), moved, mv_exp);
      chk($sformatf("e_blocked_k%0d", k), blocked, bl_exp);
    end
    chk("e_final_hor", hor_block, 9);
    move_req = 1'b0;
    step(); step();

    // Reset in CHECK with button held; held button is not a new press
    do_load(4'd0);
    vert_block = 4'd7; move_req = 1'b1;
    step(); step(); step();
    chk("f_check_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("f_rst_hor", hor_block, 4);
    chk("f_rst_moved", moved, 0);
    chk("f_rst_blocked", blocked, 0);
    chk("f_rst_busy", busy, 0);
    chk("f_rst_row_rd", row_rd, 0);
    step();
    rst = 1'b0;
    rd_mark = rd_cnt;
    events = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (moved === 1'b1 || blocked === 1'b1) events++;
    end
    chk("f_hold_events", events, 0);
    chk("f_hold_reads", rd_cnt, rd_mark);
    chk("f_hold_hor", hor_block, 4);
    move_req = 1'b0;
    step();
    move_req = 1'b1;
    step();
    chk("f_repress_row_rd", row_rd, 1);
    move_req = 1'b0;
    step(); step();
    chk("f_repress_moved", moved, 1);
    chk("f_repress_hor", hor_block, 5);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
